// File: rtl/lifo_stack.sv
// Parametrised LIFO stack: push / pop / replace-top, registered pop output,
// combinational top-of-stack peek, level/full/empty status and sticky error flags.
module lifo_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       pop_valid,
  output logic [WIDTH-1:0]           top_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       empty,
  output logic                       full,
  input  logic                       err_clr,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int AW    = $clog2(DEPTH);

  // push/pop are one-cycle strobes with no back-pressure: every strobe is acted on
  // or rejected in the cycle it is seen, and rejections are recorded in the sticky flags.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;
  logic             replace_top;
  logic             push_ok;
  logic             pop_ok;
  logic             ovf_ev;
  logic             udf_ev;

  assign empty   = (level == '0);
  assign full    = (level == LVL_W'(DEPTH));
  assign wr_idx  = AW'(level);
  assign top_idx = AW'(level - LVL_W'(1));

  always_comb begin
    replace_top = 1'b0;
    push_ok     = 1'b0;
    pop_ok      = 1'b0;
    ovf_ev      = 1'b0;
    udf_ev      = 1'b0;
    if (push && pop) begin
      // On an empty stack the push still goes through; only the pop half is rejected.
      replace_top = !empty;
      push_ok     = empty;
      pop_ok      = !empty;
      udf_ev      = empty;
    end else if (push) begin
      push_ok = !full;
      ovf_ev  = full;
    end else if (pop) begin
      pop_ok = !empty;
      udf_ev = empty;
    end
  end

  assign top_data = empty ? '0 : mem[top_idx];

  // Storage is never cleared; a reset cycle simply suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (replace_top)  mem[top_idx] <= push_data;
      else if (push_ok) mem[wr_idx]  <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level     <= '0;
      pop_data  <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pop_valid <= pop_ok;
      if (pop_ok) pop_data <= mem[top_idx];
      if (push_ok)                level <= level + LVL_W'(1);
      else if (pop_ok && !push)   level <= level - LVL_W'(1);
      // A new error in the same cycle as err_clr leaves the flag set.
      overflow  <= ovf_ev | (overflow  & ~err_clr);
      underflow <= udf_ev | (underflow & ~err_clr);
    end
  end

endmodule
